// File: rtl/wtm_seq_mult.sv
// Sequential 10x10 unsigned multiplier: four passes over one 5x5 Wallace tree, start/busy/done handshake.
// Optional macro WTM_SEQ_COUT_CHK_EN adds a sticky cout_err flag fed by the tree's carry-out.
`timescale 1ns/1ps

module wtm (
  input  logic [4:0] in1,
  input  logic [4:0] in2,
  output logic [9:0] result,
  output logic       cout
);
  logic [9:0] pp [5];
  logic [9:0] s1, c1, s2, c2, s3, c3;

  for (genvar i = 0; i < 5; i++) begin : g_pp
    assign pp[i] = {5'b0, in1 & {5{in2[i]}}} << i;
  end

  // Carry-save rows; bit 9 carries can never fire since the true sum is below 1024.
  assign s1 = pp[0] ^ pp[1] ^ pp[2];
  assign c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
  assign s2 = s1 ^ c1 ^ pp[3];
  assign c2 = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
  assign s3 = s2 ^ c2 ^ pp[4];
  assign c3 = ((s2 & c2) | (s2 & pp[4]) | (c2 & pp[4])) << 1;
  assign {cout, result} = {1'b0, s3} + {1'b0, c3};
endmodule

module wtm_seq_mult #(
  parameter int DONE_HOLD = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  a,
  input  logic [9:0]  b,
  output logic        busy,
  output logic        done,
`ifdef WTM_SEQ_COUT_CHK_EN
  output logic        cout_err,
`endif
  output logic [19:0] product
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  pass_q, pass_d;
  logic [9:0]  a_q, a_d, b_q, b_d;
  logic [19:0] acc_q, acc_d, prod_q, prod_d;
  logic        done_q, done_d;
  logic [4:0]  m_in1, m_in2;
  logic [9:0]  m_res;
  logic [19:0] m_shifted, m_sum;

`ifdef WTM_SEQ_COUT_CHK_EN
  logic m_cout;
  logic err_q, err_d;

  wtm u_wtm (.in1(m_in1), .in2(m_in2), .result(m_res), .cout(m_cout));
`else
  wtm u_wtm (.in1(m_in1), .in2(m_in2), .result(m_res), .cout());
`endif

  always_comb begin
    m_in1     = 5'd0;
    m_in2     = 5'd0;
    m_shifted = {10'b0, m_res};
    if (state_q == MUL) begin
      case (pass_q)
        2'd0: begin m_in1 = a_q[4:0]; m_in2 = b_q[4:0]; m_shifted = {10'b0, m_res}; end
        2'd1: begin m_in1 = a_q[4:0]; m_in2 = b_q[9:5]; m_shifted = {5'b0, m_res, 5'b0}; end
        2'd2: begin m_in1 = a_q[9:5]; m_in2 = b_q[4:0]; m_shifted = {5'b0, m_res, 5'b0}; end
        default: begin m_in1 = a_q[9:5]; m_in2 = b_q[9:5]; m_shifted = {m_res, 10'b0}; end
      endcase
    end
  end

  assign m_sum = acc_q + m_shifted;

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MUL;
          a_d     = a;
          b_d     = b;
          acc_d   = 20'd0;
          pass_d  = 2'd0;
          done_d  = 1'b0;
        end
      end
      MUL: begin
        acc_d  = m_sum;
        pass_d = pass_q + 2'd1;
        if (pass_q == 2'd3) begin
          prod_d  = m_sum;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = (DONE_HOLD != 0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pass_q  <= 2'd0;
      a_q     <= 10'd0;
      b_q     <= 10'd0;
      acc_q   <= 20'd0;
      prod_q  <= 20'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

`ifdef WTM_SEQ_COUT_CHK_EN
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start) err_d = 1'b0;
    else if (state_q == MUL && m_cout) err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign cout_err = err_q;
`endif

  assign busy    = (state_q == MUL) || (state_q == DONE);
  assign done    = done_q;
  assign product = prod_q;
endmodule

// File: tb/tb_wtm_seq_mult.sv
// Bench for wtm_seq_mult: pulse-done and held-done instances on shared stimulus, checked against a cycle-count model.
`timescale 1ns/1ps

module tb_wtm_seq_mult;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  a = 10'd0;
  logic [9:0]  b = 10'd0;
  logic        busy0, done0, busy1, done1;
  logic [19:0] prod0, prod1;
`ifdef WTM_SEQ_COUT_CHK_EN
  logic        err0, err1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Model: op_age counts edges since the accepting edge (0 = idle, 5 = result cycle).
  int          op_age = 0;
  logic [19:0] m_pend = 20'd0;
  logic [19:0] m_prod = 20'd0;
  logic        m_hold = 1'b0;

  always #5 clock = ~clock;

  wtm_seq_mult #(.DONE_HOLD(0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0),
`ifdef WTM_SEQ_COUT_CHK_EN
    .cout_err(err0),
`endif
    .product(prod0)
  );

  wtm_seq_mult #(.DONE_HOLD(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1),
`ifdef WTM_SEQ_COUT_CHK_EN
    .cout_err(err1),
`endif
    .product(prod1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      op_age = 0;
      m_pend = 20'd0;
      m_prod = 20'd0;
      m_hold = 1'b0;
    end else if (op_age == 0) begin
      if (start) begin
        m_pend = 20'(a) * 20'(b);
        op_age = 1;
        m_hold = 1'b0;
      end
    end else if (op_age == 5) begin
      op_age = 0;
    end else begin
      op_age = op_age + 1;
      if (op_age == 5) begin
        m_prod = m_pend;
        m_hold = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("busy0", 32'(busy0), 32'(op_age != 0));
      chk("busy1", 32'(busy1), 32'(op_age != 0));
      chk("done0", 32'(done0), 32'(op_age == 5));
      chk("done1", 32'(done1), 32'(m_hold));
      chk("product0", 32'(prod0), 32'(m_prod));
      chk("product1", 32'(prod1), 32'(m_prod));
`ifdef WTM_SEQ_COUT_CHK_EN
      chk("cout_err0", 32'(err0), 32'd0);
      chk("cout_err1", 32'(err1), 32'd0);
`endif
    end
  end

  // Starts one op from an idle negedge; checks latency, the held old product, and the literal result.
  task automatic run_op(input logic [9:0] x, input logic [9:0] y,
                        input logic [19:0] lit, input logic [19:0] prev);
    int lat;
    lat = -1;
    a = x; b = y; start = 1'b1;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      @(negedge clock);
      if (i == 1) begin
        start = 1'b0;
        a = 10'($urandom);
        b = 10'($urandom);
      end
      if (i == 3) chk("product_held", 32'(prod0), 32'(prev));
      if (done0) lat = i;
    end
    chk("latency", lat, 5);
    chk("result0", 32'(prod0), 32'(lit));
    chk("result1", 32'(prod1), 32'(lit));
    @(negedge clock);
    chk("done_hold_idle", 32'(done1), 32'd1);
  endtask

  task automatic wait_done(output int got);
    got = 0;
    for (int i = 1; i <= 12 && got == 0; i++) begin
      @(negedge clock);
      if (done0) got = i;
    end
    if (got == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int g;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_product", 32'(prod0), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op(10'd18, 10'd2, 20'd36, 20'd0);
    run_op(10'd1023, 10'd1023, 20'hFF801, 20'd36);
    run_op(10'd600, 10'd37, 20'd22200, 20'hFF801);
    run_op(10'd0, 10'd1023, 20'd0, 20'd22200);

    // A second start while busy must be ignored.
    a = 10'd18; b = 10'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    a = 10'd5; b = 10'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(g);
    chk("ignored_start_result", 32'(prod0), 32'd36);
    @(negedge clock);
    chk("busy_after_done", 32'(busy0), 32'd0);
    repeat (3) @(negedge clock);
    chk("no_extra_done", 32'(done0), 32'd0);

    // Asynchronous reset while pass 2 is in progress.
    a = 10'd600; b = 10'd37; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy0), 32'd0);
    chk("async_rst_done", 32'(done1), 32'd0);
    chk("async_rst_product", 32'(prod0), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_op(10'd31, 10'd31, 20'd961, 20'd0);

    // Start held high: second op is accepted on the first idle cycle.
    a = 10'd18; b = 10'd2; start = 1'b1;
    wait_done(g);
    chk("b2b_first", 32'(prod0), 32'd36);
    b = 10'd3;
    wait_done(g);
    chk("b2b_second", 32'(prod1), 32'd54);
    chk("b2b_gap", g, 6);
    start = 1'b0;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 500; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a = 10'($urandom);
      b = 10'($urandom);
      @(negedge clock);
    end
    start = 1'b0;
    repeat (8) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
